// File: rtl/vrp_arb_pkg.sv
// Shared defaults and sizing helpers for the arbiter request buffer.
package vrp_arb_pkg;

    localparam int VRP_WIDTH     = 8;
    localparam int VRP_PLD_WIDTH = 32;
    localparam int VRP_DEPTH     = 4;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int lane_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vrp_req_lane_fifo.sv
// Single-lane first-word-fall-through FIFO with a registered upstream ready.
module vrp_req_lane_fifo
    import vrp_arb_pkg::*;
#(
    parameter int PLD_WIDTH = VRP_PLD_WIDTH,
    parameter int DEPTH     = VRP_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_vld,
    input  logic [PLD_WIDTH-1:0]         push_pld,
    output logic                         push_rdy,
    output logic                         head_vld,
    output logic [PLD_WIDTH-1:0]         head_pld,
    input  logic                         pop_req,
    output logic [lane_cnt_w(DEPTH)-1:0] cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = lane_cnt_w(DEPTH);

    logic [PLD_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        cnt_nxt;
    logic                 push;
    logic                 pop;

    // Grants against an empty lane are dropped here, so spurious pops never move state.
    assign push     = push_vld & push_rdy;
    assign head_vld = (cnt != '0);
    assign pop      = pop_req & head_vld;
    assign head_pld = mem[rd_ptr];

    // Next occupancy; push+pop together leaves it unchanged.
    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    // Pointers, occupancy and ready; ready is taken from next occupancy so a
    // pop on a full lane only reopens it one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            push_rdy <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt      <= cnt_nxt;
            push_rdy <= (cnt_nxt < CW'(DEPTH));
        end
    end

    // Payload storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_pld;
    end

endmodule

// File: rtl/vrp_arb_req_buf.sv
// Per-lane request buffering in front of a fixed-priority arbiter.
module vrp_arb_req_buf
    import vrp_arb_pkg::*;
#(
    parameter int WIDTH     = VRP_WIDTH,
    parameter int PLD_WIDTH = VRP_PLD_WIDTH,
    parameter int DEPTH     = VRP_DEPTH
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [WIDTH-1:0]                         in_vld,
    input  logic [PLD_WIDTH-1:0]                     in_pld [WIDTH],
    output logic [WIDTH-1:0]                         in_rdy,
    output logic [WIDTH-1:0]                         v_vld_s,
    output logic [PLD_WIDTH-1:0]                     v_pld_s [WIDTH],
    input  logic [WIDTH-1:0]                         v_rdy_s,
    output logic [WIDTH-1:0][lane_cnt_w(DEPTH)-1:0]  lane_cnt
);

    // One independent FIFO per lane; lanes share nothing but the clock and reset.
    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        vrp_req_lane_fifo #(
            .PLD_WIDTH (PLD_WIDTH),
            .DEPTH     (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push_vld (in_vld[g]),
            .push_pld (in_pld[g]),
            .push_rdy (in_rdy[g]),
            .head_vld (v_vld_s[g]),
            .head_pld (v_pld_s[g]),
            .pop_req  (v_rdy_s[g]),
            .cnt      (lane_cnt[g])
        );
    end

endmodule
